color_correction_matrix: RTL and testbench



---
 rtl/color_correction_matrix_if.sv | 28 ++
 rtl/color_correction_matrix.sv | 188 ++++++++++++++++++
 tb/tb_color_correction_matrix.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/color_correction_matrix_if.sv
// AXI4-Stream bundle shared by the video pipeline stages.
interface axi4_stream_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEST_WIDTH = 4
) ();

  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tuser;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
    output tready
  );

endinterface

// File: rtl/color_correction_matrix.sv
// 3x3 colour correction matrix: out = M x in per pixel, signed fixed-point
// coefficients, round-half-up and saturate. Coefficients are staged in a
// shadow bank and swapped into the active bank on the SOF beat only.
module color_correction_matrix #(
  parameter int unsigned PX_WIDTH        = 10,
  parameter int unsigned FRACT_WIDTH     = 10,
  parameter int unsigned COEF_INT_WIDTH  = 3,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned DEST_WIDTH      = 4,
  localparam int unsigned COEF_WIDTH     = COEF_INT_WIDTH + FRACT_WIDTH,
  localparam int unsigned TDATA_WIDTH    = ((3 * PX_WIDTH + 7) / 8) * 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  axi4_stream_if.slave                 video_i,
  axi4_stream_if.master                video_o,
  input  logic signed [COEF_WIDTH-1:0] coef_data_i,
  input  logic [3:0]                   coef_addr_i,
  input  logic                         coef_wr_i,
  input  logic                         coef_commit_i,
  output logic                         coef_pending_o
);

  localparam int unsigned KEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int unsigned PROD_WIDTH = PX_WIDTH + COEF_WIDTH + 1;
  localparam int unsigned SUM_WIDTH  = PROD_WIDTH + 2;
  localparam int unsigned SIDE_WIDTH = 2 + 2 * KEEP_WIDTH + ID_WIDTH + DEST_WIDTH;
  localparam int unsigned NumCoef    = 9;

  localparam logic signed [COEF_WIDTH-1:0] CoefOne   = COEF_WIDTH'(2 ** FRACT_WIDTH);
  localparam logic signed [SUM_WIDTH:0]    RoundHalf = (SUM_WIDTH + 1)'(2 ** (FRACT_WIDTH - 1));
  localparam logic [PX_WIDTH-1:0]          PxMax     = '1;

  // Handshake / control
  logic en;
  logic accept;
  logic swap;
  logic pending_q, pending_d;

  // Coefficient banks
  logic signed [COEF_WIDTH-1:0] shadow_q [NumCoef];
  logic signed [COEF_WIDTH-1:0] active_q [NumCoef];
  logic signed [COEF_WIDTH-1:0] coef_sel [NumCoef];

  // Datapath
  logic signed [PX_WIDTH:0]       px_s   [3];
  logic signed [PROD_WIDTH-1:0]   prod_d [NumCoef];
  logic signed [PROD_WIDTH-1:0]   prod_q [NumCoef];
  logic signed [SUM_WIDTH-1:0]    sum_d  [3];
  logic signed [SUM_WIDTH-1:0]    sum_q  [3];
  logic [TDATA_WIDTH-1:0]         out_data_d, out_data_q;
  logic [PX_WIDTH-1:0]            ch_out [3];

  // Valids and sideband travelling with each beat
  logic                  s1_valid_q, s2_valid_q, out_valid_q;
  logic [SIDE_WIDTH-1:0] side_in, s1_side_q, s2_side_q, out_side_q;

  function automatic logic signed [COEF_WIDTH-1:0] ident_coef(input int unsigned idx);
    return (idx == 0 || idx == 4 || idx == 8) ? CoefOne : '0;
  endfunction

  // Round half up, arithmetic shift, then clamp to [0, 2^PX_WIDTH-1].
  function automatic logic [PX_WIDTH-1:0] round_sat(input logic signed [SUM_WIDTH-1:0] s);
    logic signed [SUM_WIDTH:0] t;
    t = {s[SUM_WIDTH-1], s} + RoundHalf;
    t = t >>> FRACT_WIDTH;
    if (t[SUM_WIDTH]) begin
      return '0;
    end else if (|t[SUM_WIDTH-1:PX_WIDTH]) begin
      return PxMax;
    end else begin
      return t[PX_WIDTH-1:0];
    end
  endfunction

  assign en     = video_o.tready | ~out_valid_q;
  assign accept = video_i.tvalid & en;
  assign swap   = accept & video_i.tuser & pending_q;

  assign video_i.tready = en;
  assign coef_pending_o = pending_q;

  assign side_in = {video_i.tlast, video_i.tuser, video_i.tstrb, video_i.tkeep,
                    video_i.tid, video_i.tdest};

  assign video_o.tvalid = out_valid_q;
  assign video_o.tdata  = out_data_q;
  assign {video_o.tlast, video_o.tuser, video_o.tstrb, video_o.tkeep,
          video_o.tid, video_o.tdest} = out_side_q;

  // Commit request is held until the next accepted SOF beat; a commit seen
  // while already pending (or on the swap beat itself) changes nothing.
  always_comb begin
    pending_d = pending_q;
    if (swap) begin
      pending_d = 1'b0;
    end else if (coef_commit_i) begin
      pending_d = 1'b1;
    end
  end

  // Coefficient banks: swap copies the pre-write shadow, then any write lands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      for (int unsigned i = 0; i < NumCoef; i++) begin
        shadow_q[i] <= ident_coef(i);
        active_q[i] <= ident_coef(i);
      end
    end else begin
      pending_q <= pending_d;
      if (swap) begin
        for (int unsigned i = 0; i < NumCoef; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (coef_wr_i && (coef_addr_i < 4'd9)) begin
        shadow_q[coef_addr_i] <= coef_data_i;
      end
    end
  end

  // S1 operands: the swapping SOF beat already uses the shadow values.
  always_comb begin
    px_s[0] = $signed({1'b0, video_i.tdata[3*PX_WIDTH-1:2*PX_WIDTH]});  // R
    px_s[1] = $signed({1'b0, video_i.tdata[PX_WIDTH-1:0]});             // G
    px_s[2] = $signed({1'b0, video_i.tdata[2*PX_WIDTH-1:PX_WIDTH]});    // B
    for (int unsigned i = 0; i < NumCoef; i++) begin
      coef_sel[i] = swap ? shadow_q[i] : active_q[i];
    end
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        prod_d[r*3+c] = PROD_WIDTH'(px_s[c]) * PROD_WIDTH'(coef_sel[r*3+c]);
      end
    end
  end

  // S2 operands: row sums of the registered products.
  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      sum_d[r] = SUM_WIDTH'(prod_q[r*3]) + SUM_WIDTH'(prod_q[r*3+1])
               + SUM_WIDTH'(prod_q[r*3+2]);
    end
  end

  // S3 operands: round/saturate each row and repack, pad bits zero.
  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      ch_out[r] = round_sat(sum_q[r]);
    end
    out_data_d = '0;
    out_data_d[3*PX_WIDTH-1:0] = {ch_out[0], ch_out[2], ch_out[1]};
  end

  // Three-stage pipeline; every stage (valids included) moves only on en.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_side_q   <= '0;
      s2_side_q   <= '0;
      out_side_q  <= '0;
      out_data_q  <= '0;
      for (int unsigned i = 0; i < NumCoef; i++) begin
        prod_q[i] <= '0;
      end
      for (int unsigned r = 0; r < 3; r++) begin
        sum_q[r] <= '0;
      end
    end else if (en) begin
      s1_valid_q  <= video_i.tvalid;
      s1_side_q   <= side_in;
      s2_valid_q  <= s1_valid_q;
      s2_side_q   <= s1_side_q;
      out_valid_q <= s2_valid_q;
      out_side_q  <= s2_side_q;
      out_data_q  <= out_data_d;
      for (int unsigned i = 0; i < NumCoef; i++) begin
        prod_q[i] <= prod_d[i];
      end
      for (int unsigned r = 0; r < 3; r++) begin
        sum_q[r] <= sum_d[r];
      end
    end
  end

endmodule

// File: tb/tb_color_correction_matrix.sv
// Self-checking bench for color_correction_matrix: directed steps plus a
// randomized backpressure run against a behavioural scoreboard.
module tb_color_correction_matrix;

  localparam int TW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(TW), .ID_WIDTH(4), .DEST_WIDTH(4)) vin ();
  axi4_stream_if #(.DATA_WIDTH(TW), .ID_WIDTH(4), .DEST_WIDTH(4)) vout ();

  logic signed [12:0] coef_data;
  logic [3:0]         coef_addr;
  logic               coef_wr;
  logic               coef_commit;
  logic               pending;

  color_correction_matrix dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .video_i        (vin),
    .video_o        (vout),
    .coef_data_i    (coef_data),
    .coef_addr_i    (coef_addr),
    .coef_wr_i      (coef_wr),
    .coef_commit_i  (coef_commit),
    .coef_pending_o (pending)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [17:0] side;
  } beat_t;

  int    sh [9];
  int    ac [9];
  bit    pend;
  beat_t exp_q [$];
  int    n_in  = 0;
  int    n_out = 0;

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) begin
      sh[i] = (i == 0 || i == 4 || i == 8) ? 1024 : 0;
      ac[i] = sh[i];
    end
    pend = 1'b0;
    exp_q.delete();
  endfunction

  // out[row] = clamp(floor((sum_c M[row][c]*in[c] + 512) / 1024)), in = {R,G,B}
  function automatic logic [31:0] ref_px(input int c [9], input int r, input int g, input int b);
    int px [3];
    int o  [3];
    int s;
    px[0] = r; px[1] = g; px[2] = b;
    for (int row = 0; row < 3; row++) begin
      s = c[row*3] * px[0] + c[row*3+1] * px[1] + c[row*3+2] * px[2];
      s = (s + 512) >>> 10;
      if (s < 0) s = 0;
      else if (s > 1023) s = 1023;
      o[row] = s;
    end
    return {2'b00, o[0][9:0], o[2][9:0], o[1][9:0]};
  endfunction

  function automatic logic [31:0] pack(input int r, input int g, input int b);
    return {2'b00, r[9:0], b[9:0], g[9:0]};
  endfunction

  logic [17:0] side_in, side_out;
  assign side_in  = {vin.tlast, vin.tuser, vin.tstrb, vin.tkeep, vin.tid, vin.tdest};
  assign side_out = {vout.tlast, vout.tuser, vout.tstrb, vout.tkeep, vout.tid, vout.tdest};

  // Scoreboard: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      beat_t e;
      int    use_c [9];
      bit    sof_swap;
      check("in_ready", vin.tready, !(vout.tvalid && !vout.tready));
      check("pending", pending, pend);
      if (vout.tvalid && vout.tready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", vout.tvalid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", vout.tdata, e.data);
          check("out_side", side_out, e.side);
          n_out++;
        end
      end
      sof_swap = vin.tvalid && vin.tready && vin.tuser && pend;
      if (vin.tvalid && vin.tready) begin
        use_c  = sof_swap ? sh : ac;
        e.data = ref_px(use_c, int'(vin.tdata[29:20]), int'(vin.tdata[9:0]),
                        int'(vin.tdata[19:10]));
        e.side = side_in;
        exp_q.push_back(e);
        n_in++;
      end
      if (sof_swap) begin
        ac   = sh;
        pend = 1'b0;
      end else if (coef_commit) begin
        pend = 1'b1;
      end
      if (coef_wr && coef_addr < 4'd9) sh[coef_addr] = int'(coef_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_beat(input int r, input int g, input int b, input bit sof, input bit last);
    vin.tvalid = 1'b1;
    vin.tdata  = pack(r, g, b);
    vin.tuser  = sof;
    vin.tlast  = last;
    vin.tstrb  = 4'($urandom);
    vin.tkeep  = 4'($urandom);
    vin.tid    = 4'($urandom);
    vin.tdest  = 4'($urandom);
  endtask

  // One beat on an idle pipeline with tready_o=1: valid exactly 3 cycles later.
  task automatic send_check(input string tag, input int r, input int g, input int b,
                            input bit sof, input int er, input int eg, input int eb);
    @(posedge clk); #1;
    drive_beat(r, g, b, sof, 1'b0);
    @(negedge clk);
    check({tag, "_accept"}, vin.tready, 1'b1);
    @(posedge clk); #1;
    vin.tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_early"}, vout.tvalid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, vout.tvalid, 1'b1);
    check({tag, "_data"}, vout.tdata, pack(er, eg, eb));
  endtask

  task automatic write_coef(input int addr, input int val);
    @(posedge clk); #1;
    coef_wr   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = 13'(val);
    @(posedge clk); #1;
    coef_wr   = 1'b0;
  endtask

  task automatic commit();
    @(posedge clk); #1;
    coef_commit = 1'b1;
    @(posedge clk); #1;
    coef_commit = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int  sent;
    int  cyc;
    bit  acc;

    vin.tvalid = 1'b0; vin.tdata = '0; vin.tuser = 1'b0; vin.tlast = 1'b0;
    vin.tstrb = '0; vin.tkeep = '0; vin.tid = '0; vin.tdest = '0;
    vout.tready = 1'b1;
    coef_data = '0; coef_addr = '0; coef_wr = 1'b0; coef_commit = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", vout.tvalid, 1'b0);
    check("rst_tdata", vout.tdata, 32'h0);
    check("rst_side", side_out, 18'h0);
    check("rst_pending", pending, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. Identity passthrough
    send_check("ident0", 100, 200, 300, 1'b1, 100, 200, 300);
    send_check("ident1", 1023, 0, 512, 1'b0, 1023, 0, 512);

    // 2. Frame-boundary swap of R and G rows
    write_coef(0, 0);
    write_coef(1, 1024);
    write_coef(3, 1024);
    write_coef(4, 0);
    commit();
    @(negedge clk);
    check("swap_pending_set", pending, 1'b1);
    send_check("swap_midframe", 10, 20, 30, 1'b0, 10, 20, 30);
    send_check("swap_sof", 10, 20, 30, 1'b1, 20, 10, 30);
    check("swap_pending_clr", pending, 1'b0);

    // 3. Saturation (row R = c0*R + G; G out = R)
    write_coef(0, 2048);
    commit();
    send_check("sat_hi", 1000, 0, 0, 1'b1, 1023, 1000, 0);
    write_coef(0, -1024);
    commit();
    send_check("sat_lo", 5, 0, 0, 1'b1, 0, 5, 0);

    // 4. Rounding
    write_coef(0, 512);
    commit();
    send_check("rnd_3", 3, 0, 0, 1'b1, 2, 3, 0);
    send_check("rnd_2", 2, 0, 0, 1'b0, 1, 2, 0);
    write_coef(0, -512);
    commit();
    send_check("rnd_neg", 3, 0, 0, 1'b1, 0, 3, 0);

    // 5. Random traffic and backpressure with a mid-stream coefficient update
    for (int i = 0; i < 9; i++) write_coef(i, int'($urandom_range(0, 2047)) - 512);
    commit();
    sent = 0;
    cyc  = 0;
    @(posedge clk); #1;
    while (sent < 1000 && cyc < 20000) begin
      vout.tready = 1'($urandom);
      if (!vin.tvalid && $urandom_range(0, 1) == 1) begin
        drive_beat(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 1023)), (sent % 50) == 0, (sent % 50) == 49);
      end
      coef_wr     = (cyc >= 300 && cyc < 309) || cyc == 150;
      coef_addr   = (cyc == 150) ? 4'd12 : 4'(cyc - 300);
      coef_data   = 13'(int'($urandom_range(0, 2047)) - 512);
      coef_commit = (cyc == 309);
      @(negedge clk);
      acc = vin.tvalid && vin.tready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        vin.tvalid = 1'b0;
      end
    end
    coef_wr = 1'b0;
    coef_commit = 1'b0;
    vin.tvalid = 1'b0;
    vout.tready = 1'b1;
    check("rand_sent", sent, 1000);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("rand_drained", exp_q.size(), 0);
    check("rand_count", n_out, n_in);

    // 6. Reset mid-frame with beats in flight and a pending commit
    write_coef(4, 0);
    commit();
    @(negedge clk);
    check("rstmid_pending", pending, 1'b1);
    vout.tready = 1'b0;
    @(posedge clk); #1; drive_beat(1, 2, 3, 1'b0, 1'b0);
    @(posedge clk); #1; drive_beat(4, 5, 6, 1'b0, 1'b0);
    @(posedge clk); #1; drive_beat(7, 8, 9, 1'b0, 1'b0);
    @(posedge clk); #1;
    vin.tvalid = 1'b0;
    check("rstmid_inflight", vout.tvalid, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rstmid_tvalid", vout.tvalid, 1'b0);
    check("rstmid_pend_clr", pending, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vout.tready = 1'b1;
    send_check("post_rst_ident", 7, 8, 9, 1'b1, 7, 8, 9);

    // Writes to unmapped addresses leave every coefficient untouched
    write_coef(12, 2048);
    commit();
    send_check("addr12_ignored", 7, 8, 9, 1'b1, 7, 8, 9);
    check("addr12_pend_clr", pending, 1'b0);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
